// File: rtl/output_port_credit_tx_pkg.sv
// Shared router constants and types for the credit-based output port.
package output_port_credit_tx_pkg;

    localparam int unsigned CREDIT_W           = 3;
    localparam int unsigned CREDIT_MAX_DEFAULT = 3;
    localparam int unsigned STAGE_DEPTH        = 2;
    localparam int unsigned STAGE_PTR_W        = 1;
    localparam int unsigned STAGE_CNT_W        = 2;

    typedef logic [CREDIT_W-1:0]    credit_t;
    typedef logic [STAGE_PTR_W-1:0] stage_ptr_t;
    typedef logic [STAGE_CNT_W-1:0] stage_cnt_t;

    // Circular pointer advance, wrapping at the staging depth.
    function automatic stage_ptr_t ptr_next(input stage_ptr_t p);
        if (p == STAGE_PTR_W'(STAGE_DEPTH - 1)) begin
            return '0;
        end
        return p + STAGE_PTR_W'(1);
    endfunction

endpackage

// File: rtl/output_port_credit_tx_credit_counter.sv
// Downstream credit counter: +1 per returned credit, -1 per send, saturating at CREDIT_MAX.
// With CREDIT_OVERFLOW_CHECK_EN defined, an overflow sets a sticky credit_error.
module credit_counter
    import output_port_credit_tx_pkg::*;
#(
    parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    credit_in,
    input  logic    consume,
    output credit_t credit_count,
    output logic    credit_error
);

    localparam credit_t CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

    credit_t count_next_c;

    // A returned credit and a send on the same edge cancel out.
    always_comb begin
        count_next_c = credit_count;
        if (credit_in && !consume) begin
            if (credit_count != CREDIT_FULL) begin
                count_next_c = credit_count + CREDIT_W'(1);
            end
        end else if (consume && !credit_in && (credit_count != '0)) begin
            count_next_c = credit_count - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_count <= CREDIT_FULL;
        end else begin
            credit_count <= count_next_c;
        end
    end

`ifdef CREDIT_OVERFLOW_CHECK_EN
    logic overflow_c;

    assign overflow_c = credit_in && !consume && (credit_count == CREDIT_FULL);

    // Sticky until reset so software can observe a lost-credit event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_error <= 1'b0;
        end else if (overflow_c) begin
            credit_error <= 1'b1;
        end
    end
`else
    assign credit_error = 1'b0;
`endif

endmodule

// File: rtl/output_port_credit_tx.sv
// Credit-based output port: 2-entry staging buffer feeding a registered TX stage.
// Optional sticky overflow flag enabled by CREDIT_OVERFLOW_CHECK_EN.
module output_port_credit_tx
    import output_port_credit_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  ready_out,
    input  logic                  credit_in,
    output logic [DATA_WIDTH-1:0] TX,
    output logic                  valid_out,
    output credit_t               credit_count,
    output logic                  credit_error
);

    logic [DATA_WIDTH-1:0] stage_mem [STAGE_DEPTH];
    stage_ptr_t            wr_ptr;
    stage_ptr_t            rd_ptr;
    stage_cnt_t            occupancy;
    logic                  push;
    logic                  send;

    assign ready_out = (occupancy < STAGE_CNT_W'(STAGE_DEPTH));
    assign push      = data_in_valid && ready_out;
    assign send      = (occupancy != '0) && (credit_count != '0);

    credit_counter #(
        .CREDIT_MAX (CREDIT_MAX)
    ) u_credit_counter (
        .clk          (clk),
        .reset        (reset),
        .credit_in    (credit_in),
        .consume      (send),
        .credit_count (credit_count),
        .credit_error (credit_error)
    );

    // Payload storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            stage_mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (send) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !send) begin
                occupancy <= occupancy + STAGE_CNT_W'(1);
            end else if (send && !push) begin
                occupancy <= occupancy - STAGE_CNT_W'(1);
            end
        end
    end

    // Head is always read from storage, so a fresh push reaches TX one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TX        <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= send;
            if (send) begin
                TX <= stage_mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_output_port_credit_tx.sv
// Directed self-checking bench for output_port_credit_tx (credit_error expectation follows CREDIT_OVERFLOW_CHECK_EN).
module tb_output_port_credit_tx;
    import output_port_credit_tx_pkg::*;

    localparam int unsigned DW = 32;

`ifdef CREDIT_OVERFLOW_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          ready_out;
    logic          credit_in;
    logic [DW-1:0] TX;
    logic          valid_out;
    credit_t       credit_count;
    logic          credit_error;

    int checks = 0;
    int fails  = 0;

    output_port_credit_tx #(
        .DATA_WIDTH (DW),
        .CREDIT_MAX (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .ready_out     (ready_out),
        .credit_in     (credit_in),
        .TX            (TX),
        .valid_out     (valid_out),
        .credit_count  (credit_count),
        .credit_error  (credit_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; data_in = '0; data_in_valid = 1'b0; credit_in = 1'b0;
        #12;
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", valid_out); end
        checks++; if (TX !== 32'h0) begin fails++; $display("FAIL rst_tx: got %h exp 0", TX); end
        checks++; if (credit_count !== 3'd3) begin fails++; $display("FAIL rst_credit: got %0d exp 3", credit_count); end
        checks++; if (credit_error !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", credit_error); end
        checks++; if (ready_out !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b exp 1", ready_out); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_credit_stall();
        data_in = 32'hA1; data_in_valid = 1'b1;
        tick();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL no_bypass: valid_out %b exp 0", valid_out); end
        data_in = 32'hA2;
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'hA1) begin fails++; $display("FAIL stall_a1: v=%b tx=%h exp 1/a1", valid_out, TX); end
        checks++; if (credit_count !== 3'd2) begin fails++; $display("FAIL stall_cc2: got %0d exp 2", credit_count); end
        data_in = 32'hA3;
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'hA2) begin fails++; $display("FAIL stall_a2: v=%b tx=%h exp 1/a2", valid_out, TX); end
        checks++; if (credit_count !== 3'd1) begin fails++; $display("FAIL stall_cc1: got %0d exp 1", credit_count); end
        data_in = 32'hA4;
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'hA3) begin fails++; $display("FAIL stall_a3: v=%b tx=%h exp 1/a3", valid_out, TX); end
        checks++; if (credit_count !== 3'd0) begin fails++; $display("FAIL stall_cc0: got %0d exp 0", credit_count); end
        data_in_valid = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b0 || TX !== 32'hA3) begin fails++; $display("FAIL stall_hold: v=%b tx=%h exp 0/a3", valid_out, TX); end
        checks++; if (ready_out !== 1'b1) begin fails++; $display("FAIL stall_ready: got %b exp 1", ready_out); end
        checks++; if (credit_count !== 3'd0) begin fails++; $display("FAIL stall_cc0b: got %0d exp 0", credit_count); end
    endtask

    task automatic test_full_ignore();
        data_in = 32'hB1; data_in_valid = 1'b1;
        tick();
        data_in = 32'hBB;
        #1;
        checks++; if (ready_out !== 1'b0) begin fails++; $display("FAIL full_ready: got %b exp 0", ready_out); end
        tick();
        data_in_valid = 1'b0;
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL full_nosend: got %b exp 0", valid_out); end
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd1 || valid_out !== 1'b0) begin fails++; $display("FAIL full_cred: cc=%0d v=%b exp 1/0", credit_count, valid_out); end
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'hA4) begin fails++; $display("FAIL full_send: v=%b tx=%h exp 1/a4", valid_out, TX); end
        checks++; if (credit_count !== 3'd0 || ready_out !== 1'b1) begin fails++; $display("FAIL full_after: cc=%0d rdy=%b exp 0/1", credit_count, ready_out); end
        tick();
        checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL full_once: got %b exp 0", valid_out); end
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'hB1) begin fails++; $display("FAIL full_b1: v=%b tx=%h exp 1/b1", valid_out, TX); end
        credit_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL full_bb_dropped: cycle %0d v=%b tx=%h exp 0", i, valid_out, TX); end
        end
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd3) begin fails++; $display("FAIL full_refill: got %0d exp 3", credit_count); end
    endtask

    task automatic test_same_edge();
        data_in = 32'hC1; data_in_valid = 1'b1;
        tick();
        data_in = 32'hC2;
        tick();
        data_in_valid = 1'b0;
        checks++; if (credit_count !== 3'd2 || TX !== 32'hC1) begin fails++; $display("FAIL same_pre: cc=%0d tx=%h exp 2/c1", credit_count, TX); end
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || TX !== 32'hC2) begin fails++; $display("FAIL same_send: v=%b tx=%h exp 1/c2", valid_out, TX); end
        checks++; if (credit_count !== 3'd2) begin fails++; $display("FAIL same_cc: got %0d exp 2", credit_count); end
        tick();
        checks++; if (valid_out !== 1'b0 || credit_count !== 3'd2) begin fails++; $display("FAIL same_after: v=%b cc=%0d exp 0/2", valid_out, credit_count); end
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd3) begin fails++; $display("FAIL same_restore: got %0d exp 3", credit_count); end
    endtask

    task automatic test_overflow();
        checks++; if (credit_error !== 1'b0) begin fails++; $display("FAIL ovf_pre: got %b exp 0", credit_error); end
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd3) begin fails++; $display("FAIL ovf_sat: got %0d exp 3", credit_count); end
        checks++; if (credit_error !== EXP_ERR) begin fails++; $display("FAIL ovf_err: got %b exp %b", credit_error, EXP_ERR); end
        tick();
        tick();
        checks++; if (credit_error !== EXP_ERR) begin fails++; $display("FAIL ovf_sticky: got %b exp %b", credit_error, EXP_ERR); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_tx;
        for (int i = 0; i < 12; i++) begin
            data_in_valid = (i < 10);
            data_in       = 32'hD0 + DW'(i);
            credit_in     = 1'b1;
            tick();
            checks++;
            if (i >= 1 && i <= 10) begin
                exp_tx = 32'hD0 + DW'(i - 1);
                if (valid_out !== 1'b1 || TX !== exp_tx) begin fails++; $display("FAIL b2b_flit%0d: v=%b tx=%h exp 1/%h", i - 1, valid_out, TX, exp_tx); end
            end else begin
                if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_idle%0d: v=%b exp 0", i, valid_out); end
            end
            checks++; if (ready_out !== 1'b1 || credit_count !== 3'd3) begin fails++; $display("FAIL b2b_state%0d: rdy=%b cc=%0d exp 1/3", i, ready_out, credit_count); end
        end
        credit_in = 1'b0; data_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            data_in = 32'hF1 + DW'(i); data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        checks++; if (credit_count !== 3'd1 || ready_out !== 1'b0) begin fails++; $display("FAIL mid_pre: cc=%0d rdy=%b exp 1/0", credit_count, ready_out); end
        checks++; if (TX !== 32'hF3) begin fails++; $display("FAIL mid_tx: got %h exp f3", TX); end
        reset = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || credit_count !== 3'd3) begin fails++; $display("FAIL mid_async: v=%b cc=%0d exp 0/3", valid_out, credit_count); end
        checks++; if (TX !== 32'h0 || ready_out !== 1'b1 || credit_error !== 1'b0) begin fails++; $display("FAIL mid_clear: tx=%h rdy=%b err=%b exp 0/1/0", TX, ready_out, credit_error); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_out !== 1'b0) begin fails++; $display("FAIL mid_empty%0d: v=%b tx=%h exp 0", i, valid_out, TX); end
        end
        data_in = 32'h61; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        checks++; if (valid_out !== 1'b1 || TX !== 32'h61 || credit_count !== 3'd2) begin fails++; $display("FAIL mid_resume: v=%b tx=%h cc=%0d exp 1/61/2", valid_out, TX, credit_count); end
    endtask

    initial begin
        test_reset();
        test_credit_stall();
        test_full_ignore();
        test_same_edge();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
